// File: rtl/hpdcache_victim_arb.sv
// hpdcache_victim_arb: owns the PLRU update/select ports, arbitrating core, victim-mark and refill updates.
// Optional saturating event counters are built when HPDCACHE_VICTIM_ARB_STATS_EN is defined.
package hpdcache_victim_arb_pkg;
    typedef struct packed {
        int unsigned sets;
        int unsigned ways;
    } hpdcache_user_cfg_t;

    typedef struct packed {
        hpdcache_user_cfg_t u;
    } hpdcache_cfg_t;
endpackage

module hpdcache_victim_arb
    import hpdcache_victim_arb_pkg::*;
#(
    parameter hpdcache_cfg_t HPDcacheCfg = '0,
    parameter int unsigned   FifoDepth   = 4,
    // A zero-valued configuration falls back to a 64-set, 4-way geometry
    localparam int unsigned  Sets = (HPDcacheCfg.u.sets == 0) ? 64 : HPDcacheCfg.u.sets,
    localparam int unsigned  Ways = (HPDcacheCfg.u.ways == 0) ? 4 : HPDcacheCfg.u.ways,
    localparam int unsigned  SetW = $clog2(Sets),
    localparam int unsigned  WayW = Ways
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            core_updt_i,
    input  logic [SetW-1:0] core_updt_set_i,
    input  logic [WayW-1:0] core_updt_way_i,

    input  logic            refill_updt_valid_i,
    output logic            refill_updt_ready_o,
    input  logic [SetW-1:0] refill_updt_set_i,
    input  logic [WayW-1:0] refill_updt_way_i,

    input  logic            victim_req_valid_i,
    output logic            victim_req_ready_o,
    input  logic [SetW-1:0] victim_req_set_i,
    input  logic [WayW-1:0] victim_req_dir_valid_i,
    input  logic [WayW-1:0] victim_req_dir_wback_i,
    input  logic [WayW-1:0] victim_req_dir_dirty_i,
    input  logic [WayW-1:0] victim_req_dir_fetch_i,

    output logic            victim_rsp_valid_o,
    input  logic            victim_rsp_ready_i,
    output logic [WayW-1:0] victim_rsp_way_o,

    output logic            plru_updt_o,
    output logic [SetW-1:0] plru_updt_set_o,
    output logic [WayW-1:0] plru_updt_way_o,

    output logic            plru_sel_victim_o,
    output logic [SetW-1:0] plru_sel_set_o,
    output logic [WayW-1:0] plru_sel_dir_valid_o,
    output logic [WayW-1:0] plru_sel_dir_wback_o,
    output logic [WayW-1:0] plru_sel_dir_dirty_o,
    output logic [WayW-1:0] plru_sel_dir_fetch_o,
    input  logic [WayW-1:0] plru_sel_way_i,

    output logic [31:0]     stat_core_o,
    output logic [31:0]     stat_refill_o,
    output logic [31:0]     stat_hazard_o
);

    localparam int unsigned     PtrW    = $clog2(FifoDepth);
    localparam int unsigned     CntW    = $clog2(FifoDepth + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(FifoDepth);

    typedef enum logic [1:0] {IDLE, SEL, RSP} state_e;

    state_e state_q, state_d;

    logic [SetW-1:0] fifo_set_q [FifoDepth];
    logic [WayW-1:0] fifo_way_q [FifoDepth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;

    logic            mark_valid_q;
    logic [SetW-1:0] mark_set_q;
    logic [WayW-1:0] mark_way_q;
    logic            mark_win;

    logic [SetW-1:0] req_set_q;
    logic [WayW-1:0] req_valid_q, req_wback_q, req_dirty_q, req_fetch_q;
    logic [WayW-1:0] rsp_way_q;

    logic            fifo_hazard, hazard;
    logic            req_ready, req_accept, sel_active, rsp_active;

    assign fifo_full  = (count_q == FullCnt);
    assign fifo_empty = (count_q == '0);
    assign fifo_push  = refill_updt_valid_i && !fifo_full;
    assign mark_win   = !core_updt_i && mark_valid_q;
    assign fifo_pop   = !core_updt_i && !mark_valid_q && !fifo_empty;

    assign refill_updt_ready_o = !fifo_full;

    // Fixed priority: core hit, then victim mark, then oldest refill
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        plru_updt_o     = 1'b0;
        plru_updt_set_o = '0;
        plru_updt_way_o = '0;
        if (core_updt_i) begin
            plru_updt_o     = 1'b1;
            plru_updt_set_o = core_updt_set_i;
            plru_updt_way_o = core_updt_way_i;
        end else if (mark_valid_q) begin
            plru_updt_o     = 1'b1;
            plru_updt_set_o = mark_set_q;
            plru_updt_way_o = mark_way_q;
        end else if (!fifo_empty) begin
            plru_updt_o     = 1'b1;
            plru_updt_set_o = fifo_set_q[rptr_q];
            plru_updt_way_o = fifo_way_q[rptr_q];
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy
    always_comb begin
        fifo_hazard = 1'b0;
        for (int i = 0; i < FifoDepth; i++) begin
            if ((CntW'(PtrW'(PtrW'(i) - rptr_q)) < count_q) &&
                (fifo_set_q[i] == victim_req_set_i)) begin
                fifo_hazard = 1'b1;
            end
        end
    end

    assign hazard = fifo_hazard
                 || (mark_valid_q && (mark_set_q == victim_req_set_i))
                 || (core_updt_i && (core_updt_set_i == victim_req_set_i));

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        sel_active = 1'b0;
        rsp_active = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !hazard && !mark_valid_q;
                if (victim_req_valid_i && req_ready) state_d = SEL;
            end
            SEL: begin
                sel_active = 1'b1;
                state_d    = RSP;
            end
            RSP: begin
                rsp_active = 1'b1;
                if (victim_rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_accept = victim_req_valid_i && req_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: FIFO storage has no reset; the occupancy counter alone defines which entries are valid.
    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_set_q[wptr_q] <= refill_updt_set_i;
            fifo_way_q[wptr_q] <= refill_updt_way_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (fifo_push) wptr_q <= wptr_q + PtrW'(1);
            if (fifo_pop)  rptr_q <= rptr_q + PtrW'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_set_q    <= '0;
            req_valid_q  <= '0;
            req_wback_q  <= '0;
            req_dirty_q  <= '0;
            req_fetch_q  <= '0;
            rsp_way_q    <= '0;
            mark_valid_q <= 1'b0;
            mark_set_q   <= '0;
            mark_way_q   <= '0;
        end else begin
            if (req_accept) begin
                req_set_q   <= victim_req_set_i;
                req_valid_q <= victim_req_dir_valid_i;
                req_wback_q <= victim_req_dir_wback_i;
                req_dirty_q <= victim_req_dir_dirty_i;
                req_fetch_q <= victim_req_dir_fetch_i;
            end
            if (sel_active) rsp_way_q <= plru_sel_way_i;
            // The slot is always empty in SEL, so load and drain never collide
            if (sel_active && (plru_sel_way_i != '0)) begin
                mark_valid_q <= 1'b1;
                mark_set_q   <= req_set_q;
                mark_way_q   <= plru_sel_way_i;
            end else if (mark_win) begin
                mark_valid_q <= 1'b0;
            end
        end
    end

    assign victim_req_ready_o   = req_ready;
    assign victim_rsp_valid_o   = rsp_active;
    assign victim_rsp_way_o     = rsp_active ? rsp_way_q : '0;
    assign plru_sel_victim_o    = sel_active;
    assign plru_sel_set_o       = sel_active ? req_set_q   : '0;
    assign plru_sel_dir_valid_o = sel_active ? req_valid_q : '0;
    assign plru_sel_dir_wback_o = sel_active ? req_wback_q : '0;
    assign plru_sel_dir_dirty_o = sel_active ? req_dirty_q : '0;
    assign plru_sel_dir_fetch_o = sel_active ? req_fetch_q : '0;

`ifdef HPDCACHE_VICTIM_ARB_STATS_EN
    logic [31:0] stat_core_q, stat_refill_q, stat_hazard_q;
    logic        hazard_evt;

    assign hazard_evt = (state_q == IDLE) && victim_req_valid_i && hazard;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_core_q   <= '0;
            stat_refill_q <= '0;
            stat_hazard_q <= '0;
        end else begin
            if (core_updt_i && (stat_core_q != '1))  stat_core_q   <= stat_core_q + 32'd1;
            if (fifo_pop && (stat_refill_q != '1))   stat_refill_q <= stat_refill_q + 32'd1;
            if (hazard_evt && (stat_hazard_q != '1)) stat_hazard_q <= stat_hazard_q + 32'd1;
        end
    end

    assign stat_core_o   = stat_core_q;
    assign stat_refill_o = stat_refill_q;
    assign stat_hazard_o = stat_hazard_q;
`else
    assign stat_core_o   = '0;
    assign stat_refill_o = '0;
    assign stat_hazard_o = '0;
`endif

endmodule

// File: tb/tb_hpdcache_victim_arb.sv
// Directed testbench for hpdcache_victim_arb (16 sets, 4 ways, 4-entry refill FIFO).
module tb_hpdcache_victim_arb;
    import hpdcache_victim_arb_pkg::*;

    localparam hpdcache_cfg_t Cfg   = '{u: '{sets: 32'd16, ways: 32'd4}};
    localparam int unsigned   Depth = 4;
`ifdef HPDCACHE_VICTIM_ARB_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       core_updt_i = 1'b0;
    logic [3:0] core_updt_set_i = '0, core_updt_way_i = '0;
    logic       refill_updt_valid_i = 1'b0, refill_updt_ready_o;
    logic [3:0] refill_updt_set_i = '0, refill_updt_way_i = '0;
    logic       victim_req_valid_i = 1'b0, victim_req_ready_o;
    logic [3:0] victim_req_set_i = '0;
    logic [3:0] victim_req_dir_valid_i = '0, victim_req_dir_wback_i = '0;
    logic [3:0] victim_req_dir_dirty_i = '0, victim_req_dir_fetch_i = '0;
    logic       victim_rsp_valid_o, victim_rsp_ready_i = 1'b0;
    logic [3:0] victim_rsp_way_o;
    logic       plru_updt_o;
    logic [3:0] plru_updt_set_o, plru_updt_way_o;
    logic       plru_sel_victim_o;
    logic [3:0] plru_sel_set_o;
    logic [3:0] plru_sel_dir_valid_o, plru_sel_dir_wback_o, plru_sel_dir_dirty_o, plru_sel_dir_fetch_o;
    logic [3:0] plru_sel_way_i = '0;
    logic [31:0] stat_core_o, stat_refill_o, stat_hazard_o;

    int vectors = 0;
    int miscompares = 0;

    hpdcache_victim_arb #(.HPDcacheCfg(Cfg), .FifoDepth(Depth)) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .core_updt_i          (core_updt_i),
        .core_updt_set_i      (core_updt_set_i),
        .core_updt_way_i      (core_updt_way_i),
        .refill_updt_valid_i  (refill_updt_valid_i),
        .refill_updt_ready_o  (refill_updt_ready_o),
        .refill_updt_set_i    (refill_updt_set_i),
        .refill_updt_way_i    (refill_updt_way_i),
        .victim_req_valid_i   (victim_req_valid_i),
        .victim_req_ready_o   (victim_req_ready_o),
        .victim_req_set_i     (victim_req_set_i),
        .victim_req_dir_valid_i(victim_req_dir_valid_i),
        .victim_req_dir_wback_i(victim_req_dir_wback_i),
        .victim_req_dir_dirty_i(victim_req_dir_dirty_i),
        .victim_req_dir_fetch_i(victim_req_dir_fetch_i),
        .victim_rsp_valid_o   (victim_rsp_valid_o),
        .victim_rsp_ready_i   (victim_rsp_ready_i),
        .victim_rsp_way_o     (victim_rsp_way_o),
        .plru_updt_o          (plru_updt_o),
        .plru_updt_set_o      (plru_updt_set_o),
        .plru_updt_way_o      (plru_updt_way_o),
        .plru_sel_victim_o    (plru_sel_victim_o),
        .plru_sel_set_o       (plru_sel_set_o),
        .plru_sel_dir_valid_o (plru_sel_dir_valid_o),
        .plru_sel_dir_wback_o (plru_sel_dir_wback_o),
        .plru_sel_dir_dirty_o (plru_sel_dir_dirty_o),
        .plru_sel_dir_fetch_o (plru_sel_dir_fetch_o),
        .plru_sel_way_i       (plru_sel_way_i),
        .stat_core_o          (stat_core_o),
        .stat_refill_o        (stat_refill_o),
        .stat_hazard_o        (stat_hazard_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 unit after the rising edge; outputs are checked 1 unit later
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_updt(input string tag, input logic v, input logic [3:0] s, input logic [3:0] w);
        check({tag, "_updt"}, 32'(plru_updt_o), 32'(v));
        check({tag, "_set"},  32'(plru_updt_set_o), 32'(s));
        check({tag, "_way"},  32'(plru_updt_way_o), 32'(w));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_updt(tag, 1'b0, 4'd0, 4'd0);
        check({tag, "_refill_rdy"}, 32'(refill_updt_ready_o), 32'd1);
        check({tag, "_req_rdy"},    32'(victim_req_ready_o), 32'd1);
        check({tag, "_rsp_vld"},    32'(victim_rsp_valid_o), 32'd0);
        check({tag, "_rsp_way"},    32'(victim_rsp_way_o), 32'd0);
        check({tag, "_sel"},        32'(plru_sel_victim_o), 32'd0);
        check({tag, "_sel_set"},    32'(plru_sel_set_o), 32'd0);
        check({tag, "_sel_dv"},     32'(plru_sel_dir_valid_o), 32'd0);
        check({tag, "_st_core"},    stat_core_o, 32'd0);
        check({tag, "_st_refill"},  stat_refill_o, 32'd0);
        check({tag, "_st_hazard"},  stat_hazard_o, 32'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs("rst0");
        #10 rst_ni = 1'b1;

        // Single refill appears one cycle after its push
        tick();
        refill_updt_valid_i = 1'b1; refill_updt_set_i = 4'd3; refill_updt_way_i = 4'b0100;
        #1;
        check("t1_ready", 32'(refill_updt_ready_o), 32'd1);
        check("t1_no_bypass", 32'(plru_updt_o), 32'd0);
        tick();
        refill_updt_valid_i = 1'b0;
        #1 check_updt("t1_pop", 1'b1, 4'd3, 4'b0100);
        tick();
        #1 check_updt("t1_idle", 1'b0, 4'd0, 4'd0);

        // Core update held 3 cycles defers a refill pushed in the first cycle
        tick();
        core_updt_i = 1'b1; core_updt_set_i = 4'd1; core_updt_way_i = 4'b0001;
        refill_updt_valid_i = 1'b1; refill_updt_set_i = 4'd2; refill_updt_way_i = 4'b1000;
        #1 check_updt("t2_c0", 1'b1, 4'd1, 4'b0001);
        tick();
        refill_updt_valid_i = 1'b0;
        #1 check_updt("t2_c1", 1'b1, 4'd1, 4'b0001);
        tick();
        #1 check_updt("t2_c2", 1'b1, 4'd1, 4'b0001);
        tick();
        core_updt_i = 1'b0;
        #1 check_updt("t2_refill", 1'b1, 4'd2, 4'b1000);
        tick();
        #1 check_updt("t2_empty", 1'b0, 4'd0, 4'd0);

        // Fill the FIFO behind a core update, overflow by one, then drain in order
        tick();
        core_updt_i = 1'b1; core_updt_set_i = 4'd1; core_updt_way_i = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) tick();
            refill_updt_valid_i = 1'b1;
            refill_updt_set_i   = 4'(8 + k);
            refill_updt_way_i   = 4'(1 << k);
            #1;
            check($sformatf("t3_rdy%0d", k), 32'(refill_updt_ready_o), 32'd1);
            check($sformatf("t3_core%0d", k), 32'(plru_updt_set_o), 32'd1);
        end
        tick();
        refill_updt_set_i = 4'd12; refill_updt_way_i = 4'b0001;
        #1;
        check("t3_full", 32'(refill_updt_ready_o), 32'd0);
        check_updt("t3_core4", 1'b1, 4'd1, 4'b0001);
        tick();
        core_updt_i = 1'b0;
        #1;
        check("t3_full_pop", 32'(refill_updt_ready_o), 32'd0);
        check_updt("t3_d8", 1'b1, 4'd8, 4'b0001);
        tick();
        #1;
        check("t3_rdy_again", 32'(refill_updt_ready_o), 32'd1);
        check_updt("t3_d9", 1'b1, 4'd9, 4'b0010);
        tick();
        refill_updt_valid_i = 1'b0;
        #1 check_updt("t3_d10", 1'b1, 4'd10, 4'b0100);
        tick();
        #1 check_updt("t3_d11", 1'b1, 4'd11, 4'b1000);
        tick();
        #1 check_updt("t3_d12", 1'b1, 4'd12, 4'b0001);
        tick();
        #1 check_updt("t3_empty", 1'b0, 4'd0, 4'd0);

        // FIFO entry on set 5 blocks a victim request until it pops; no-way response
        tick();
        core_updt_i = 1'b1; core_updt_set_i = 4'd1; core_updt_way_i = 4'b0001;
        refill_updt_valid_i = 1'b1; refill_updt_set_i = 4'd5; refill_updt_way_i = 4'b0010;
        tick();
        refill_updt_valid_i = 1'b0;
        victim_req_valid_i = 1'b1; victim_req_set_i = 4'd5;
        victim_req_dir_valid_i = 4'b1110; victim_req_dir_wback_i = 4'b0100;
        victim_req_dir_dirty_i = 4'b0110; victim_req_dir_fetch_i = 4'b0001;
        #1 check("t4_blk0", 32'(victim_req_ready_o), 32'd0);
        tick();
        core_updt_i = 1'b0;
        #1;
        check("t4_blk1", 32'(victim_req_ready_o), 32'd0);
        check_updt("t4_pop5", 1'b1, 4'd5, 4'b0010);
        tick();
        #1 check("t4_accept", 32'(victim_req_ready_o), 32'd1);
        tick();
        victim_req_valid_i = 1'b0; victim_req_set_i = 4'd0;
        victim_req_dir_valid_i = '0; victim_req_dir_wback_i = '0;
        victim_req_dir_dirty_i = '0; victim_req_dir_fetch_i = '0;
        plru_sel_way_i = 4'b0000;
        #1;
        check("t4_sel", 32'(plru_sel_victim_o), 32'd1);
        check("t4_sel_set", 32'(plru_sel_set_o), 32'd5);
        check("t4_sel_dv", 32'(plru_sel_dir_valid_o), 32'b1110);
        check("t4_sel_wb", 32'(plru_sel_dir_wback_o), 32'b0100);
        check("t4_sel_dy", 32'(plru_sel_dir_dirty_o), 32'b0110);
        check("t4_sel_ft", 32'(plru_sel_dir_fetch_o), 32'b0001);
        check("t4_sel_rdy", 32'(victim_req_ready_o), 32'd0);
        tick();
        victim_rsp_ready_i = 1'b1;
        #1;
        check("t4_rsp_vld", 32'(victim_rsp_valid_o), 32'd1);
        check("t4_rsp_way", 32'(victim_rsp_way_o), 32'd0);
        check_updt("t4_nomark", 1'b0, 4'd0, 4'd0);
        check("t4_sel_off", 32'(plru_sel_set_o), 32'd0);
        tick();
        victim_rsp_ready_i = 1'b0;
        #1;
        check("t4_idle_vld", 32'(victim_rsp_valid_o), 32'd0);
        check("t4_idle_rdy", 32'(victim_req_ready_o), 32'd1);

        // Victim on set 7 with PLRU answer 0b0010, response held 3 cycles
        tick();
        victim_req_valid_i = 1'b1; victim_req_set_i = 4'd7;
        victim_req_dir_valid_i = 4'b1111; victim_req_dir_wback_i = 4'b0101;
        victim_req_dir_dirty_i = 4'b0011; victim_req_dir_fetch_i = 4'b1000;
        #1 check("t5_accept", 32'(victim_req_ready_o), 32'd1);
        tick();
        victim_req_valid_i = 1'b0; victim_req_set_i = 4'd0;
        victim_req_dir_valid_i = '0; victim_req_dir_wback_i = '0;
        victim_req_dir_dirty_i = '0; victim_req_dir_fetch_i = '0;
        plru_sel_way_i = 4'b0010;
        #1;
        check("t5_sel", 32'(plru_sel_victim_o), 32'd1);
        check("t5_sel_set", 32'(plru_sel_set_o), 32'd7);
        check("t5_sel_dv", 32'(plru_sel_dir_valid_o), 32'b1111);
        check("t5_sel_ft", 32'(plru_sel_dir_fetch_o), 32'b1000);
        check("t5_sel_novld", 32'(victim_rsp_valid_o), 32'd0);
        tick();
        plru_sel_way_i = 4'b0000;
        #1;
        check("t5_rsp0_vld", 32'(victim_rsp_valid_o), 32'd1);
        check("t5_rsp0_way", 32'(victim_rsp_way_o), 32'b0010);
        check_updt("t5_mark", 1'b1, 4'd7, 4'b0010);
        tick();
        #1;
        check("t5_rsp1_vld", 32'(victim_rsp_valid_o), 32'd1);
        check("t5_rsp1_way", 32'(victim_rsp_way_o), 32'b0010);
        check_updt("t5_mark_gone", 1'b0, 4'd0, 4'd0);
        check("t5_rsp1_rdy", 32'(victim_req_ready_o), 32'd0);
        tick();
        #1;
        check("t5_rsp2_vld", 32'(victim_rsp_valid_o), 32'd1);
        check("t5_rsp2_way", 32'(victim_rsp_way_o), 32'b0010);
        tick();
        victim_rsp_ready_i = 1'b1;
        #1;
        check("t5_rsp3_vld", 32'(victim_rsp_valid_o), 32'd1);
        check("t5_rsp3_way", 32'(victim_rsp_way_o), 32'b0010);
        tick();
        victim_rsp_ready_i = 1'b0;
        #1;
        check("t5_done_vld", 32'(victim_rsp_valid_o), 32'd0);
        check("t5_done_way", 32'(victim_rsp_way_o), 32'd0);
        check("t5_done_rdy", 32'(victim_req_ready_o), 32'd1);

        // Core cycles 3+5+2, FIFO pops 1+1+5+1, hazard-blocked IDLE cycles 2
        check("stat_core",   stat_core_o,   StatsEn ? 32'd10 : 32'd0);
        check("stat_refill", stat_refill_o, StatsEn ? 32'd8  : 32'd0);
        check("stat_hazard", stat_hazard_o, StatsEn ? 32'd2  : 32'd0);

        // Reset while in RSP with two refills queued behind a core update
        tick();
        core_updt_i = 1'b1; core_updt_set_i = 4'd1; core_updt_way_i = 4'b0001;
        refill_updt_valid_i = 1'b1; refill_updt_set_i = 4'd3; refill_updt_way_i = 4'b0100;
        victim_req_valid_i = 1'b1; victim_req_set_i = 4'd9; victim_req_dir_valid_i = 4'b1111;
        #1 check("t6_accept", 32'(victim_req_ready_o), 32'd1);
        tick();
        refill_updt_set_i = 4'd4; refill_updt_way_i = 4'b1000;
        victim_req_valid_i = 1'b0; victim_req_set_i = 4'd0; victim_req_dir_valid_i = '0;
        plru_sel_way_i = 4'b0100;
        #1 check("t6_sel", 32'(plru_sel_victim_o), 32'd1);
        tick();
        refill_updt_valid_i = 1'b0;
        plru_sel_way_i = 4'b0000;
        #1 check("t6_rsp", 32'(victim_rsp_valid_o), 32'd1);
        core_updt_i = 1'b0;
        rst_ni = 1'b0;
        #1 check_reset_outputs("t6_rst");
        tick();
        tick();
        rst_ni = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("t6_post%0d_updt", k), 32'(plru_updt_o), 32'd0);
            check($sformatf("t6_post%0d_rsp", k), 32'(victim_rsp_valid_o), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
